regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with scoreboard pending bits and a sweep-clear engine.
// Latency: combinational reads (optional same-cycle write forwarding); writes land at the clock edge.
// Backpressure: none; while a sweep runs, writes, issues and further clear requests are dropped.
module regfile_sb #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int BYPASS   = 1,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            reg_write,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] rd_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            clr_req,
   output logic            clr_busy,
   output logic            clr_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   state_t                      state_q, state_d;
   logic [AW-1:0]               idx_q, idx_d;
   logic [NREG-1:0][XLEN-1:0]   regs_q, regs_d;
   logic [NREG-1:0]             pend_q, pend_d;

   logic wr_en;
   logic iss_en;

   // Qualified write/issue: only in IDLE with no clear request, and never to a hardwired r0.
   always_comb begin
      wr_en  = reg_write && (state_q == IDLE) && !clr_req
               && !((ZERO_REG != 0) && (rd == '0));
      iss_en = issue_valid && (state_q == IDLE) && !clr_req
               && !((ZERO_REG != 0) && (issue_rd == '0));
   end

   // Next-state for the clear FSM, the register array and the pending bits.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               // A clear request wins over any coincident write or issue.
               state_d = SWEEP;
               idx_d   = '0;
               pend_d  = '0;
            end else begin
               if (wr_en) begin
                  regs_d[rd] = rd_data;
                  pend_d[rd] = 1'b0;
               end
               // Applied after the write so an issue to the same register keeps it pending.
               if (iss_en) begin
                  pend_d[issue_rd] = 1'b1;
               end
            end
         end
         SWEEP: begin
            regs_d[idx_q] = '0;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State registers with asynchronous clear of everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         regs_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         regs_q  <= regs_d;
         pend_q  <= pend_d;
      end
   end

   function automatic logic fwd_hit(input logic [AW-1:0] a);
      return (BYPASS != 0) && wr_en && (rd == a);
   endfunction

   function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
      if ((ZERO_REG != 0) && (a == '0)) return '0;
      if (fwd_hit(a))                   return rd_data;
      return regs_q[a];
   endfunction

   function automatic logic read_busy(input logic [AW-1:0] a);
      if ((ZERO_REG != 0) && (a == '0))                  return 1'b0;
      // A forwarded write retires the hazard unless the same register is reissued this cycle.
      if (fwd_hit(a) && !(iss_en && (issue_rd == a)))   return 1'b0;
      return pend_q[a];
   endfunction

   // Combinational read ports and status outputs.
   always_comb begin
      rs1_data = read_data(rs1);
      rs2_data = read_data(rs2);
      rs1_busy = read_busy(rs1);
      rs2_busy = read_busy(rs2);
      clr_busy = (state_q != IDLE);
      clr_done = (state_q == DONE);
   end

endmodule
